// File: rtl/out_display_pkg.sv
// Shared constants, FSM encoding and helper functions for the output-register display.
// The optional feature is enabled by the macro OUT_DISPLAY_SIGNED_EN.
package out_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam int CONV_STEPS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // One double-dabble step on {hundreds, tens, ones, binary}: add 3 to nibbles >= 5, shift left.
    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[8+4*i +: 4] >= 4'd5)
                t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/out_display_bin2bcd.sv
// Serial 8-bit binary to 3-digit BCD converter (double-dabble), one shift per cycle.
// start is honoured only in IDLE; done pulses for the single COMMIT cycle while dout is valid.
module out_display_bin2bcd
    import out_display_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  din,
    output logic        busy,
    output logic        done,
    output logic [11:0] dout
);

    conv_state_t state, state_next;
    logic [2:0]  cnt;
    logic [19:0] shift;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: defaulting state_next before the case keeps this block purely combinational (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CONV;
            CONV:    if (cnt == 3'(CONV_STEPS - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift <= {12'b0, din};
                        cnt   <= '0;
                    end
                end
                CONV: begin
                    shift <= dabble_step(shift);
                    cnt   <= cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == COMMIT);
    end

    assign dout = shift[19:8];

endmodule

// File: rtl/out_display.sv
// Samples the CPU output register, converts it to BCD and scans a 4-digit 7-segment display.
// Define OUT_DISPLAY_SIGNED_EN to treat value as two's complement with a minus sign on digit 3.
module out_display
    import out_display_pkg::*;
#(
    parameter int CLK_DIV = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  value,
    output logic [6:0]  seg,
    output logic [3:0]  dig_en,
    output logic [11:0] bcd,
    output logic        busy
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [7:0]    src;
    logic [7:0]    mag;
    logic          value_sign;
    logic          pending_sign;
    logic          sign;
    logic          start;
    logic          done;
    logic [11:0]   result;
    logic [PW-1:0] prescaler;
    logic [1:0]    idx;

`ifdef OUT_DISPLAY_SIGNED_EN
    assign mag        = value[7] ? (~value + 8'd1) : value;
    assign value_sign = value[7];
`else
    assign mag        = value;
    assign value_sign = 1'b0;
`endif

    // A new conversion launches only from IDLE, so mid-conversion changes wait for the next pass.
    assign start = !busy && (value != src);

    out_display_bin2bcd u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .din     (mag),
        .busy    (busy),
        .done    (done),
        .dout    (result)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src          <= '0;
            pending_sign <= 1'b0;
            bcd          <= '0;
            sign         <= 1'b0;
        end else begin
            if (start) begin
                src          <= value;
                pending_sign <= value_sign;
            end
            if (done) begin
                bcd  <= result;
                sign <= pending_sign;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (prescaler == PW'(CLK_DIV - 1)) begin
            prescaler <= '0;
            idx       <= idx + 2'd1;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    assign dig_en = 4'b0001 << idx;

    // Leading-zero blanking: ones always lit, tens only when the number has >= 2 digits.
    always_comb begin
        seg = SEG_BLANK;
        case (idx)
            2'd0: seg = glyph(bcd[3:0]);
            2'd1: seg = (bcd[11:4] != 8'h00) ? glyph(bcd[7:4]) : SEG_BLANK;
            2'd2: seg = (bcd[11:8] != 4'h0) ? glyph(bcd[11:8]) : SEG_BLANK;
            2'd3: seg = sign ? SEG_MINUS : SEG_BLANK;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: tb/tb_out_display.sv
// Self-checking bench for out_display: directed scenarios plus random values against an
// arithmetic reference model (decimal digits by division, scan position by cycle count).
module tb_out_display;

    localparam int CLK_DIV = 3;
`ifdef OUT_DISPLAY_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [7:0]  value;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic [11:0] bcd;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int k = 0;          // clock edges since the last reset edge
    int shown = 0;      // value whose conversion is currently committed

    logic [6:0] glyph_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                   7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    out_display #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .value   (value),
        .seg     (seg),
        .dig_en  (dig_en),
        .bcd     (bcd),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) k <= reset_n ? k + 1 : 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int mag_of(input int v);
        if (SIGNED_MODE && v >= 128) return 256 - v;
        return v;
    endfunction

    function automatic bit neg_of(input int v);
        return SIGNED_MODE && (v >= 128);
    endfunction

    function automatic logic [11:0] exp_bcd(input int v);
        int m;
        m = mag_of(v);
        return 12'((m / 100) * 256 + ((m / 10) % 10) * 16 + (m % 10));
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int pos);
        int m;
        m = mag_of(v);
        case (pos)
            0: return glyph_tab[m % 10];
            1: return (m >= 10) ? glyph_tab[(m / 10) % 10] : 7'b0;
            2: return (m >= 100) ? glyph_tab[m / 100] : 7'b0;
            default: return neg_of(v) ? 7'b1000000 : 7'b0;
        endcase
    endfunction

    task automatic scan_check(input string tag);
        int pos;
        pos = (k / CLK_DIV) % 4;
        check({tag, "_dig_en"}, 32'(dig_en), 32'(1 << pos));
        check({tag, "_seg"}, 32'(seg), 32'(exp_seg(shown, pos)));
    endtask

    // Applies v, then checks the documented latency and the committed result.
    task automatic convert(input string tag, input int v);
        value = 8'(v);
        for (int c = 0; c <= 9; c++) begin
            tick();
            if (c == 1) check({tag, "_busy_hi"}, 32'(busy), 1);
            if (c == 8) check({tag, "_bcd_hold"}, 32'(bcd), 32'(exp_bcd(shown)));
        end
        check({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd(v)));
        check({tag, "_busy_lo"}, 32'(busy), 0);
        shown = v;
    endtask

    initial begin
        bit bad;
        bit found;
        int v;
        int cur;
        logic [11:0] prev;

        // 1: reset
        reset_n = 1'b0;
        value   = 8'd0;
        tick();
        tick();
        reset_n = 1'b1;
        check("rst_bcd", 32'(bcd), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dig_en", 32'(dig_en), 1);
        check("rst_seg", 32'(seg), 32'(7'b0111111));
        for (int c = 0; c < 3; c++) tick();
        check("idle_no_conv", 32'(busy), 0);

        // 2: 0 -> 255 with exact latency
        convert("t2", 255);
        scan_check("t2");

        // 3: change during conversion is deferred, never mixed
        prev  = bcd;
        bad   = 1'b0;
        value = 8'd7;
        for (int c = 0; c <= 22; c++) begin
            tick();
            if (c == 3) value = 8'd42;
            if (bcd !== prev && bcd !== exp_bcd(7) && bcd !== exp_bcd(42)) bad = 1'b1;
            if (c == 9) check("t3_first", 32'(bcd), 32'(exp_bcd(7)));
            if (c == 18) check("t3_hold", 32'(bcd), 32'(exp_bcd(7)));
            if (c == 19) check("t3_second", 32'(bcd), 32'(exp_bcd(42)));
        end
        check("t3_no_mixed", 32'(bad), 0);
        shown = 42;

        // 5: reset during conversion, then restart
        value = 8'd200;
        for (int c = 0; c <= 2; c++) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        shown = 0;
        check("t5_rst_bcd", 32'(bcd), 0);
        check("t5_rst_busy", 32'(busy), 0);
        for (int c = 0; c <= 9; c++) begin
            tick();
            if (c == 8) check("t5_bcd_hold", 32'(bcd), 0);
        end
        check("t5_bcd", 32'(bcd), 32'(exp_bcd(200)));
        shown = 200;

        // 4: scan sequence with value 5
        convert("t4", 5);
        for (int c = 0; c < 15; c++) begin
            tick();
            scan_check("t4_scan");
        end

        // 6: 0xFB, signed or unsigned interpretation
        convert("t6", 8'hFB);
        found = 1'b0;
        for (int c = 0; c < 16 && !found; c++) begin
            tick();
            if (dig_en == 4'b1000) begin
                found = 1'b1;
                check("t6_sign_digit", 32'(seg), SIGNED_MODE ? 32'(7'b1000000) : 0);
            end
        end
        check("t6_sign_digit_seen", 32'(found), 1);

        // random values
        cur = 8'hFB;
        for (int i = 0; i < 16; i++) begin
            v = int'($urandom_range(0, 255));
            if (v == cur) v = v ^ 1;
            convert("rnd", v);
            scan_check("rnd");
            cur = v;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
